// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge
// Single-slave AHB-Lite to APB3 bridge feeding the SRAM's APB port. Each
// accepted AHB word transfer becomes one APB transfer; AHB wait states are
// inserted (hreadyout=0) until the APB slave answers with pready.
//
// Ports:
//   clk, reset           - rising-edge clock, asynchronous active-high reset
//   hsel, haddr, htrans,
//   hwrite, hwdata,
//   hready               - AHB-Lite slave inputs (word-only, haddr[1:0] ignored)
//   hreadyout, hresp,
//   hrdata               - AHB-Lite slave response
//   paddr                - APB word address (haddr[17:2])
//   pwdata, pwrite,
//   psel, penable        - APB master outputs (all registered)
//   prdata, pready       - APB slave response
//
// Optional feature: define AHB2APB_TIMEOUT_EN to abort APB accesses that wait
// TIMEOUT_CYCLES cycles without pready, answering with a two-cycle AHB ERROR.

module ahb2apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("ahb2apb_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        accept;

`ifdef AHB2APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Byte-lane bits, the unused upper address range and the SEQ/NONSEQ
  // distinction carry no meaning for a word-only single slave.
  logic unused_inputs;
  assign unused_inputs = ^{haddr[31:18], haddr[1:0], htrans[0]};

  assign accept = hsel & hready & htrans[1];

  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;

    unique case (state_q)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          paddr_d  = haddr[17:2];
          pwrite_d = hwrite;
          state_d  = hwrite ? S_CAPT : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPT: begin
        // Data phase of a write: hwdata is only valid now.
        pwdata_d = hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          state_d = S_IDLE;
          if (!pwrite_q) hrdata_d = prdata;
        end
`ifdef AHB2APB_TIMEOUT_EN
        // cnt_q counts earlier unready ACCESS cycles, so this is the
        // TIMEOUT_CYCLES-th one; a simultaneous pready wins above.
        else if (cnt_q == TO_LAST) begin
          state_d = S_ERR1;
        end
`endif
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    // APB strobes follow the next state so they are glitch-free flops.
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

`ifdef AHB2APB_TIMEOUT_EN
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_ACCESS) && (state_d == S_ACCESS)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hrdata_q  <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hrdata_q  <= hrdata_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
`ifdef AHB2APB_TIMEOUT_EN
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign hresp     = 1'b0;
`endif
  assign hrdata    = hrdata_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule
